// File: rtl/load_store_master.sv
// load_store_master
// Memory-side initiator between the core's execute stage and a word-organised
// data memory (combinational read, synchronous write). Accepts byte, halfword
// and word loads/stores (RISC-V funct3 encoding) over valid/ready. Loads are
// returned sign- or zero-extended; sub-word stores are done by
// read-modify-write.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_we, i_req_funct3, i_req_addr, i_req_wdata
//                          request channel (ready only while idle)
//   o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err
//                          response channel (held stable until accepted)
//   o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata
//                          data memory port (word-aligned byte address)
module load_store_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_r;
  logic                    req_ready_r;
  logic                    we_r;
  logic [2:0]              funct3_r;
  logic [1:0]              addr_lo_r;   // only the lane bits are needed after accept
  logic [15:0]             wdata_r;     // only SB/SH data is needed after accept
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    rsp_err_r;
  logic                    mem_we_r;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;

  // Misalignment, illegal funct3, or unsigned-store encodings.
  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic err;
    err = 1'b0;
    case (f3)
      3'b000:  err = 1'b0;
      3'b001:  err = lo[0];
      3'b010:  err = (lo != 2'b00);
      3'b100:  err = we;
      3'b101:  err = we | lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Extract the addressed lane and extend it to a full word.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/halfword lane of the word read back.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [15:0] wd,
                                              input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00) begin
      m[{lo, 3'b000} +: 8] = wd[7:0];
    end else if (lo[1]) begin
      m[31:16] = wd;
    end else begin
      m[15:0] = wd;
    end
    return m;
  endfunction

  // Request/response FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      addr_lo_r   <= 2'd0;
      wdata_r     <= 16'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_req_valid) begin
            we_r        <= i_req_we;
            funct3_r    <= i_req_funct3;
            addr_lo_r   <= i_req_addr[1:0];
            wdata_r     <= i_req_wdata[15:0];
            req_ready_r <= 1'b0;
            if (req_error(i_req_we, i_req_funct3, i_req_addr[1:0])) begin
              // Errors never touch the memory port.
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end else begin
              mem_addr_r <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (i_req_we && (i_req_funct3[1:0] == 2'b10)) begin
                // Full-word store goes straight to the write cycle.
                state_r     <= WRITE;
                mem_we_r    <= 1'b1;
                mem_wdata_r <= i_req_wdata;
              end else begin
                state_r <= READ;
              end
            end
          end
        end
        READ: begin
          if (we_r) begin
            state_r     <= WRITE;
            mem_we_r    <= 1'b1;
            mem_wdata_r <= store_merge(i_mem_rdata, wdata_r, funct3_r, addr_lo_r);
          end else begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= load_extend(i_mem_rdata, funct3_r, addr_lo_r);
          end
        end
        WRITE: begin
          state_r     <= RESP;
          mem_we_r    <= 1'b0;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= '0;
        end
        RESP: begin
          if (i_rsp_ready) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          mem_we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = req_ready_r;
  assign o_rsp_valid = rsp_valid_r;
  assign o_rsp_rdata = rsp_rdata_r;
  assign o_rsp_err   = rsp_err_r;
  // Reset in the WRITE cycle must stop the memory from committing the word.
  assign o_mem_we    = mem_we_r & ~i_rst;
  assign o_mem_addr  = mem_addr_r;
  assign o_mem_wdata = mem_wdata_r;

endmodule

// File: doc/load_store_master.md
Name: load_store_master

Overview:
- Memory-side initiator sitting between the core's execute stage and the word-organised data memory.
- Accepts byte, halfword and word load/store requests (RISC-V funct3 encoding) over a valid/ready handshake.
- Drives the data memory's write-enable, address and write-data port, which has combinational read and synchronous write.
- Returns load data sign- or zero-extended; sub-word stores are done by read-modify-write.

Parameters:
DATA_WIDTH, 32, memory word width; fixed at 32 for this block.
ADDR_WIDTH, 10, byte-address width; equals log2 of the data memory size.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_req_valid  input  1  request present
o_req_ready  output  1  block can accept a request (high only in IDLE)
i_req_we  input  1  1 = store, 0 = load
i_req_funct3  input  3  access size/sign (LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101)
i_req_addr  input  ADDR_WIDTH  byte address
i_req_wdata  input  DATA_WIDTH  store data, right-aligned
o_rsp_valid  output  1  response present
i_rsp_ready  input  1  consumer accepts response
o_rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
o_rsp_err  output  1  misaligned address or illegal funct3
o_mem_we  output  1  memory write enable
o_mem_addr  output  ADDR_WIDTH  word-aligned byte address (low 2 bits always 0)
o_mem_wdata  output  DATA_WIDTH  merged word to write
i_mem_rdata  input  DATA_WIDTH  memory read data (combinational from o_mem_addr)

Behaviour:
- Reset (i_rst high at a clock edge): state=IDLE, all request registers cleared.
  - Resulting outputs: o_req_ready=1, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0.
  - Reset in any state aborts the operation. A WRITE-state write is suppressed if reset is asserted that same cycle.
- Handshake: a request is accepted when i_req_valid and o_req_ready are both high at a clock edge.
  - addr, we, funct3 and wdata are registered on acceptance.
  - Inputs are ignored outside IDLE.
- States: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP on accept when an error is detected. No memory write occurs; err=1, rdata=0.
  - IDLE -> READ on accept of a load or a sub-word store.
  - IDLE -> WRITE on accept of SW.
  - READ: o_mem_addr = registered addr with low 2 bits cleared; i_mem_rdata is sampled at the edge.
    - Load: READ -> RESP with extended data.
    - SB/SH: READ -> WRITE with the merged word.
  - WRITE: o_mem_we=1 for exactly one cycle; o_mem_addr is the aligned address; o_mem_wdata is the full word (SW) or the merged word. WRITE -> RESP.
  - RESP: o_rsp_valid=1 and held stable until i_rsp_ready; on the handshake edge -> IDLE. No back-to-back accept in that same cycle.
- Outside WRITE: o_mem_we=0. o_mem_addr and o_mem_wdata hold their last values.
- Latency, accept edge to o_rsp_valid:
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Load: 2 cycles.
  - SB/SH: 3 cycles.
- Errors:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - funct3 in {011, 110, 111}.
  - Store with funct3[2]=1.
- Lane selection uses addr[1:0]: byte lane k = bits 8k+7:8k; halfword lane = addr[1].
- Load extension: LB/LH sign-extend from the top bit of the lane; LBU/LHU zero-extend; LW passes the word through.
- Merge (SB/SH): replace only the addressed lane with wdata[7:0] or wdata[15:0]; other lanes keep the word read in READ.
- Address wrap: none. The top word of memory is a normal access.

Test Plan:
- After reset: memory word at byte addr 0x010 = 0x11223344. LW addr 0x010 -> o_rsp_valid 2 cycles after accept, rdata=0x11223344, err=0, o_mem_we never high.
- Same word: LB addr 0x012 -> 0x00000022; preload word 0x80FF0000, LH addr 0x012 -> 0xFFFF80FF; LHU addr 0x012 -> 0x000080FF.
- Word at 0x020 = 0xAABBCCDD.
  - SB addr 0x021 wdata 0x12345677 -> exactly one o_mem_we pulse at addr 0x020, wdata 0xAABB77DD; response 3 cycles after accept.
  - Then SH addr 0x022 wdata 0x0000BEEF -> word 0xBEEF77DD.
- LW addr 0x013, SH addr 0x011, and funct3=110 -> err=1 and rdata=0 one cycle after accept, no memory write, memory unchanged.
- Hold i_rsp_ready=0 for 5 cycles after a load -> o_rsp_valid, rdata and o_req_ready=0 stable throughout; a new request with valid=1 is not accepted until after the response handshake.
- Assert i_rst during WRITE of an SB -> no o_mem_we pulse that cycle, target word unchanged, next cycle o_req_ready=1 and o_rsp_valid=0.
